wb_ram_arbiter: RTL

//  Two-master Wishbone arbiter in front of the OpenRAM Wishbone wrapper; its

---
 rtl/wb_ram_arbiter_if.sv | 15 +
 rtl/wb_ram_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/wb_ram_arbiter_if.sv
// Wishbone classic bus bundle shared by the arbiter's two upstream masters and its RAM-side port.
interface wb_ram_arbiter_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] datM2s;
    logic [31:0] datS2m;
    logic        ack;
    logic        err;

    modport master (output cyc, stb, we, sel, adr, datM2s, input ack, datS2m);
    modport slave  (input cyc, stb, we, sel, adr, datM2s, output ack, err, datS2m);
endinterface

// File: rtl/wb_ram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the OpenRAM wrapper; the grant is held per cyc.
// Define WB_ARB_TIMEOUT_EN to enable the stalled-transfer watchdog.
module wb_ram_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_CNT_W       = 5
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    wb_ram_arbiter_if.slave  m0_bus,
    wb_ram_arbiter_if.slave  m1_bus,
    wb_ram_arbiter_if.master s_bus
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

    state_e state_q, state_d;
    logic   lastGnt_q, lastGnt_d;
    logic   timeout;

`ifdef WB_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] toCnt_q, toCnt_d;
    logic                ownerCyc, ownerStb, stall;

    // Timeout fires on the cycle that would be the TIMEOUT_CYCLES-th stalled one.
    always_comb begin
        ownerCyc = 1'b0;
        ownerStb = 1'b0;
        if (state_q == GNT0) begin
            ownerCyc = m0_bus.cyc;
            ownerStb = m0_bus.stb;
        end else if (state_q == GNT1) begin
            ownerCyc = m1_bus.cyc;
            ownerStb = m1_bus.stb;
        end
        stall   = ownerCyc & ownerStb & ~s_bus.ack;
        timeout = stall && (toCnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));
        toCnt_d = toCnt_q;
        if (state_q == IDLE || s_bus.ack || timeout)
            toCnt_d = '0;
        else if (stall)
            toCnt_d = toCnt_q + 1'b1;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            toCnt_q <= '0;
        else
            toCnt_q <= toCnt_d;
    end
`else
    logic unusedCfg;
    assign unusedCfg = ^{TIMEOUT_CYCLES, TO_CNT_W};
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            lastGnt_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            lastGnt_q <= lastGnt_d;
        end
    end

    // On a tie the master that did not own the bus last wins.
    always_comb begin
        state_d   = state_q;
        lastGnt_d = lastGnt_q;
        unique case (state_q)
            IDLE: begin
                if (m0_bus.cyc && (!m1_bus.cyc || lastGnt_q))
                    state_d = GNT0;
                else if (m1_bus.cyc)
                    state_d = GNT1;
            end
            GNT0: begin
                if (!m0_bus.cyc || timeout) begin
                    state_d   = IDLE;
                    lastGnt_d = 1'b0;
                end
            end
            GNT1: begin
                if (!m1_bus.cyc || timeout) begin
                    state_d   = IDLE;
                    lastGnt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_bus.cyc     = 1'b0;
        s_bus.stb     = 1'b0;
        s_bus.we      = 1'b0;
        s_bus.sel     = '0;
        s_bus.adr     = '0;
        s_bus.datM2s  = '0;
        m0_bus.ack    = 1'b0;
        m0_bus.err    = 1'b0;
        m0_bus.datS2m = '0;
        m1_bus.ack    = 1'b0;
        m1_bus.err    = 1'b0;
        m1_bus.datS2m = '0;
        unique case (state_q)
            GNT0: begin
                s_bus.cyc     = m0_bus.cyc & ~timeout;
                s_bus.stb     = m0_bus.stb;
                s_bus.we      = m0_bus.we;
                s_bus.sel     = m0_bus.sel;
                s_bus.adr     = m0_bus.adr;
                s_bus.datM2s  = m0_bus.datM2s;
                m0_bus.ack    = s_bus.ack;
                m0_bus.err    = timeout;
                m0_bus.datS2m = s_bus.datS2m;
            end
            GNT1: begin
                s_bus.cyc     = m1_bus.cyc & ~timeout;
                s_bus.stb     = m1_bus.stb;
                s_bus.we      = m1_bus.we;
                s_bus.sel     = m1_bus.sel;
                s_bus.adr     = m1_bus.adr;
                s_bus.datM2s  = m1_bus.datM2s;
                m1_bus.ack    = s_bus.ack;
                m1_bus.err    = timeout;
                m1_bus.datS2m = s_bus.datS2m;
            end
            default: ;
        endcase
    end

endmodule
